conv_param_tx: RTL and testbench

CONV_PARAM_TX -- requirements
Module: conv_param_tx

---
 rtl/conv_pkg.sv | 37 +++
 rtl/conv_param_tx.sv | 138 +++++++++++++
 tb/tb_conv_param_tx.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared constants and types for the convolution control path:
// conv_control and its parameter transmitter conv_param_tx.
package conv_pkg;

  localparam int WORD_W   = 32;
  localparam int KADDR_W  = 8;

  // {N,C} header word field positions
  localparam int N_MSB    = 31;
  localparam int N_LSB    = 16;
  localparam int C_MSB    = 15;
  localparam int C_LSB    = 0;

  // conv_control side: header words preceding the kernel stream
  localparam int CC_HDR_WORDS = 3;
  localparam int CC_MAX_KLEN  = 255;

  typedef enum logic [2:0] {
    IDLE,
    SEND_M01,
    SEND_M02,
    SEND_CN,
    K_FETCH,
    K_LOAD,
    K_SEND,
    DONE
  } tx_state_e;

  function automatic logic [WORD_W-1:0] pack_nc(input logic [15:0] n, input logic [15:0] c);
    logic [WORD_W-1:0] w;
    w = '0;
    w[N_MSB:N_LSB] = n;
    w[C_MSB:C_LSB] = c;
    return w;
  endfunction

endpackage

// File: rtl/conv_param_tx.sv
// Streams M0, {N,C} and a kernel buffer out over a valid/ready link
// into conv_control; kernel words are fetched from an external buffer.
module conv_param_tx
  import conv_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [63:0]         i_m0,
  input  logic [15:0]         i_c,
  input  logic [15:0]         i_n,
  input  logic [7:0]          i_k_len,
  output logic                o_k_rd,
  output logic [KADDR_W-1:0]  o_k_addr,
  input  logic [WORD_W-1:0]   i_k_data,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [WORD_W-1:0]   o_data,
  output logic                o_last,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err
);

  tx_state_e           r_state;
  logic [31:0]         r_m0_hi;
  logic [15:0]         r_c;
  logic [15:0]         r_n;
  logic [7:0]          r_k_len;
  logic [7:0]          r_idx;
  logic [WORD_W-1:0]   r_data;
  logic                r_valid;
  logic                r_last;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic                r_k_rd;
  logic [KADDR_W-1:0]  r_k_addr;

  logic w_beat;
  logic w_idx_last;

  assign w_beat     = r_valid & i_ready;
  assign w_idx_last = (r_idx == (r_k_len - 8'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_m0_hi  <= '0;
      r_c      <= '0;
      r_n      <= '0;
      r_k_len  <= '0;
      r_idx    <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_k_rd   <= 1'b0;
      r_k_addr <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_k_rd <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            if (i_k_len == 8'd0) begin
              r_err <= 1'b1;
            end else begin
              // low M0 half goes straight to o_data, only the high half is kept
              r_m0_hi <= i_m0[63:32];
              r_c     <= i_c;
              r_n     <= i_n;
              r_k_len <= i_k_len;
              r_idx   <= '0;
              r_data  <= i_m0[31:0];
              r_valid <= 1'b1;
              r_busy  <= 1'b1;
              r_state <= SEND_M01;
            end
          end
        end
        SEND_M01: if (w_beat) begin
          r_data  <= r_m0_hi;
          r_state <= SEND_M02;
        end
        SEND_M02: if (w_beat) begin
          r_data  <= pack_nc(r_n, r_c);
          r_state <= SEND_CN;
        end
        SEND_CN: if (w_beat) begin
          r_valid  <= 1'b0;
          r_k_rd   <= 1'b1;
          r_k_addr <= r_idx;
          r_state  <= K_FETCH;
        end
        K_FETCH: r_state <= K_LOAD;
        K_LOAD: begin
          // buffer returns data the cycle after the read strobe
          r_data  <= i_k_data;
          r_last  <= w_idx_last;
          r_valid <= 1'b1;
          r_state <= K_SEND;
        end
        K_SEND: if (w_beat) begin
          r_valid <= 1'b0;
          if (r_last) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_idx    <= r_idx + 8'd1;
            r_k_rd   <= 1'b1;
            r_k_addr <= r_idx + 8'd1;
            r_state  <= K_FETCH;
          end
        end
        DONE: begin
          r_last  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_k_rd   = r_k_rd;
  assign o_k_addr = r_k_addr;
  assign o_valid  = r_valid;
  assign o_data   = r_data;
  assign o_last   = r_last;
  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_err    = r_err;

endmodule

// File: tb/tb_conv_param_tx.sv
// Directed + randomized bench for conv_param_tx: an expected beat list is
// built from the parameters and kernel contents, then compared with what was sent.
module tb_conv_param_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [63:0] i_m0 = '0;
  logic [15:0] i_c = '0;
  logic [15:0] i_n = '0;
  logic [7:0]  i_k_len = '0;
  logic        o_k_rd;
  logic [7:0]  o_k_addr;
  logic [31:0] i_k_data = '0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_data;
  logic        o_last;
  logic        o_busy;
  logic        o_done;
  logic        o_err;

  conv_param_tx dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_m0(i_m0), .i_c(i_c), .i_n(i_n),
    .i_k_len(i_k_len), .o_k_rd(o_k_rd), .o_k_addr(o_k_addr), .i_k_data(i_k_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_last(o_last),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  // external kernel buffer, one-cycle read latency
  logic [31:0] kmem [0:255];
  always @(posedge clk) if (o_k_rd) i_k_data <= kmem[o_k_addr];

  int checks = 0;
  int errors = 0;

  logic [32:0] got_q[$];
  logic [7:0]  addr_q[$];
  int done_cnt, err_cnt, valid_cnt, busy_cnt, hold_viol, rd_viol;
  logic        p_stall, p_rd;
  logic [32:0] p_word;
  logic [7:0]  p_addr;

  always @(negedge clk) begin
    if (!rst_n) begin
      p_stall = 1'b0; p_rd = 1'b0; p_addr = '0; p_word = '0;
    end else begin
      if (p_stall && !(o_valid && {o_last, o_data} === p_word)) hold_viol++;
      if (o_k_rd && p_rd) rd_viol++;
      if (!o_k_rd && o_k_addr !== p_addr) rd_viol++;
      if (o_k_rd) addr_q.push_back(o_k_addr);
      if (o_valid && i_ready) got_q.push_back({o_last, o_data});
      if (o_valid) valid_cnt++;
      if (o_busy) busy_cnt++;
      if (o_done) done_cnt++;
      if (o_err) err_cnt++;
      p_stall = o_valid && !i_ready;
      p_word  = {o_last, o_data};
      p_rd    = o_k_rd;
      p_addr  = o_k_addr;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    got_q.delete(); addr_q.delete();
    done_cnt = 0; err_cnt = 0; valid_cnt = 0; busy_cnt = 0; hold_viol = 0; rd_viol = 0;
  endtask

  // mode: 1 full ready, 2 stall M02 for 4 cycles, 3 reset at kernel word 1,
  //       4 random ready, 5 restart attempt during SEND_CN
  task automatic run_xfer(input logic [63:0] m0, input logic [15:0] c, input logic [15:0] n,
                          input logic [7:0] kl, input int mode, output int cyc, output bit aborted);
    int  stall;
    bit  bp_done, restart_next;
    stall = 0; bp_done = 0; restart_next = 0; aborted = 0; cyc = 0;
    clear_mon();
    i_m0 = m0; i_c = c; i_n = n; i_k_len = kl; i_start = 1'b1;
    i_ready = (mode == 4) ? ($urandom_range(0, 2) != 0) : 1'b1;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      cyc++;
      if (o_done) break;
      if (mode == 2 && !bp_done && o_valid && o_data === m0[31:0]) begin
        stall = 4; bp_done = 1;
      end
      if (mode == 5 && !bp_done && o_valid && o_data === m0[63:32]) begin
        restart_next = 1; bp_done = 1;
      end
      if (mode == 3 && o_valid && !o_last && o_data === kmem[1]) begin
        rst_n = 1'b0; aborted = 1;
        break;
      end
      @(posedge clk); #1;
      i_start = restart_next;
      if (restart_next) begin
        i_m0 = ~m0; i_c = ~c; i_n = ~n; i_k_len = 8'd7;
        restart_next = 0;
      end
      if (mode == 4) i_ready = ($urandom_range(0, 2) != 0);
      else if (stall > 0) begin i_ready = 1'b0; stall--; end
      else i_ready = 1'b1;
    end
    if (!aborted) begin
      chk("done_seen", {63'd0, o_done}, 64'd1);
      repeat (2) @(negedge clk);
      @(posedge clk); #1;
    end
  endtask

  task automatic check_stream(input string tag, input logic [63:0] m0, input logic [15:0] c,
                              input logic [15:0] n, input logic [7:0] kl);
    logic [32:0] exp_q[$];
    int mism;
    exp_q.push_back({1'b0, m0[31:0]});
    exp_q.push_back({1'b0, m0[63:32]});
    exp_q.push_back({1'b0, n, c});
    for (int i = 0; i < int'(kl); i++) exp_q.push_back({(i == int'(kl) - 1), kmem[i]});
    chk({tag, "_beats"}, 64'(got_q.size()), 64'(exp_q.size()));
    mism = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) mism++;
    chk({tag, "_word_mism"}, 64'(mism), 64'd0);
    mism = (addr_q.size() == int'(kl)) ? 0 : 1;
    for (int i = 0; i < addr_q.size(); i++) if (addr_q[i] !== 8'(i)) mism++;
    chk({tag, "_addr_walk"}, 64'(mism), 64'd0);
    chk({tag, "_done_once"}, 64'(done_cnt), 64'd1);
    chk({tag, "_hold_rd_viol"}, 64'(hold_viol + rd_viol), 64'd0);
    chk({tag, "_idle_busy"}, {63'd0, o_busy}, 64'd0);
  endtask

  initial begin
    int cyc;
    bit ab;
    logic [63:0] m0;
    logic [15:0] c, n;
    logic [7:0]  kl;

    // reset state
    #3;
    chk("reset_outs", {o_valid, o_last, o_busy, o_done, o_err, o_k_rd, o_data, o_k_addr}, 64'd0);
    #19 rst_n = 1'b1;
    @(posedge clk); #1;
    clear_mon();
    i_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("post_reset_no_beat", 64'(valid_cnt + busy_cnt), 64'd0);

    // basic transfer
    kmem[0] = 32'hA5A5A5A5; kmem[1] = 32'h5A5A5A5A;
    run_xfer(64'h1122334455667788, 16'd3, 16'd16, 8'd2, 1, cyc, ab);
    check_stream("basic", 64'h1122334455667788, 16'd3, 16'd16, 8'd2);
    chk("basic_latency", 64'(cyc), 64'd11);

    // backpressure on M02
    for (int i = 0; i < 3; i++) kmem[i] = $urandom;
    run_xfer(64'h1122334455667788, 16'h0102, 16'h0304, 8'd3, 2, cyc, ab);
    check_stream("bp", 64'h1122334455667788, 16'h0102, 16'h0304, 8'd3);
    chk("bp_latency", 64'(cyc), 64'(3 * 3 + 9));

    // zero length start
    clear_mon();
    i_k_len = 8'd0; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("zero_err_once", 64'(err_cnt), 64'd1);
    chk("zero_no_busy_valid", 64'(busy_cnt + valid_cnt), 64'd0);

    // restart attempt during SEND_CN is ignored
    m0 = {$urandom, $urandom}; c = 16'($urandom); n = 16'($urandom);
    for (int i = 0; i < 4; i++) kmem[i] = $urandom;
    run_xfer(m0, c, n, 8'd4, 5, cyc, ab);
    check_stream("restart", m0, c, n, 8'd4);
    chk("restart_latency", 64'(cyc), 64'(3 * 4 + 5));
    i_start = 1'b0;

    // reset mid-kernel, then a clean full transfer
    m0 = 64'hDEADBEEF_CAFEF00D; c = 16'h0011; n = 16'h0022;
    kmem[0] = 32'h10000000; kmem[1] = 32'h20000001; kmem[2] = 32'h30000002; kmem[3] = 32'h40000003;
    run_xfer(m0, c, n, 8'd4, 3, cyc, ab);
    chk("abort_reached", {63'd0, ab}, 64'd1);
    #1;
    chk("abort_outs_zero", {o_valid, o_last, o_busy, o_done, o_err, o_k_rd, o_data, o_k_addr}, 64'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    clear_mon();
    repeat (4) @(posedge clk); #1;
    chk("abort_no_beat", 64'(valid_cnt + busy_cnt), 64'd0);
    run_xfer(m0, c, n, 8'd4, 1, cyc, ab);
    check_stream("after_abort", m0, c, n, 8'd4);

    // full-length kernel
    for (int i = 0; i < 255; i++) kmem[i] = $urandom;
    m0 = {$urandom, $urandom};
    run_xfer(m0, 16'hFFFF, 16'h8000, 8'd255, 1, cyc, ab);
    check_stream("full255", m0, 16'hFFFF, 16'h8000, 8'd255);
    chk("full255_latency", 64'(cyc), 64'(3 * 255 + 5));

    // randomized transfers with random backpressure
    for (int r = 0; r < 5; r++) begin
      m0 = {$urandom, $urandom}; c = 16'($urandom); n = 16'($urandom);
      kl = 8'($urandom_range(1, 12));
      for (int i = 0; i < int'(kl); i++) kmem[i] = $urandom;
      run_xfer(m0, c, n, kl, 4, cyc, ab);
      check_stream("rand", m0, c, n, kl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
